// File: rtl/spi_frame_loader_if.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_loader_if
// Brief    : SPI pins, frame-buffer bus and status/debug outputs of the loader.
// Revision : 1.0 - initial release
// ============================================================================
interface spi_frame_loader_if #(
    parameter int ADDR_W = 12,
    parameter int PIX_W  = 8
);
    logic              SPI_CLK;
    logic              SPI_MOSI;
    logic              SPI_CS;
    logic              SPI_MISO;
    logic              data_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_wr_en;
    logic [PIX_W-1:0]  mem_wdata;
    logic [PIX_W-1:0]  mem_rdata;
    logic              frame_loaded;
    logic              err;
    logic [7:0]        first_byte;
    logic [7:0]        last_byte;
    logic [7:0]        curr_byte;

    modport master (
        output SPI_CLK, SPI_MOSI, SPI_CS, mem_rdata,
        input  SPI_MISO, data_valid, mem_addr, mem_wr_en, mem_wdata,
        input  frame_loaded, err, first_byte, last_byte, curr_byte
    );

    modport slave (
        input  SPI_CLK, SPI_MOSI, SPI_CS, mem_rdata,
        output SPI_MISO, data_valid, mem_addr, mem_wr_en, mem_wdata,
        output frame_loaded, err, first_byte, last_byte, curr_byte
    );
endinterface
`default_nettype wire

// File: rtl/spi_frame_loader.sv
`default_nettype none
// ============================================================================
// Module   : spi_frame_loader
// Brief    : SPI mode-0 slave that loads a frame buffer and reads it back.
// Revision : 1.0 - initial release
// ============================================================================
module spi_frame_loader #(
    parameter int IMAGEX   = 64,
    parameter int IMAGEY   = 64,
    parameter int CHANNELS = 1
) (
    input  logic            clk,
    input  logic            rst,
    spi_frame_loader_if.slave bus
);
    localparam int IMAGE_SIZE = IMAGEX * IMAGEY;
    localparam int ADDR_W     = $clog2(IMAGE_SIZE);
    localparam int PIX_W      = 8 * CHANNELS;
    localparam int CNT_W      = ADDR_W + 1;
    localparam int BIT_W      = $clog2(PIX_W + 1);

    localparam logic [CNT_W-1:0]  C_PIX_TOTAL = CNT_W'(IMAGE_SIZE);
    localparam logic [CNT_W-1:0]  C_PIX_LAST  = CNT_W'(IMAGE_SIZE - 1);
    localparam logic [ADDR_W-1:0] C_ADDR_LAST = ADDR_W'(IMAGE_SIZE - 1);
    localparam logic [1:0]        C_CH_LAST   = 2'(CHANNELS - 1);
    localparam logic [BIT_W-1:0]  C_PIX_BITS  = BIT_W'(PIX_W);
    localparam logic [7:0]        C_CMD_LOAD  = 8'h01;
    localparam logic [7:0]        C_CMD_READ  = 8'h02;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_CMD      = 3'd1;
    localparam logic [2:0] ST_LOAD     = 3'd2;
    localparam logic [2:0] ST_READBACK = 3'd3;
    localparam logic [2:0] ST_DRAIN    = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [1:0]        sclk_sync_q, mosi_sync_q, cs_sync_q;
    logic              sclk_prev_q, cs_prev_q;
    logic [2:0]        bit_cnt_q;
    logic [6:0]        rx_sh_q;
    logic [7:0]        rx_byte_q;
    logic              byte_done_q;
    logic [1:0]        byte_cnt_q;
    logic [CNT_W-1:0]  pix_cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic              wr_en_q;
    logic [PIX_W-1:0]  wdata_q;
    logic              rd_req_q, rd_cap_q;
    logic [PIX_W-1:0]  rd_buf_q, tx_sh_q;
    logic [BIT_W-1:0]  tx_bits_q;
    logic [CNT_W-1:0]  tx_pix_q;
    logic              miso_q, dv_q;
    logic              frame_loaded_q, err_q;
    logic              first_pend_q;
    logic [7:0]        first_byte_q, last_byte_q, curr_byte_q;

    logic              w_sclk_rise, w_sclk_fall, w_cs_rise, w_cs_fall;
    logic              w_byte_load, w_pix_done, w_last_wr, w_load_full;
    logic [PIX_W-1:0]  w_pix_next;

    assign w_sclk_rise = sclk_sync_q[1] & ~sclk_prev_q;
    assign w_sclk_fall = ~sclk_sync_q[1] & sclk_prev_q;
    assign w_cs_rise   = cs_sync_q[1] & ~cs_prev_q;
    assign w_cs_fall   = ~cs_sync_q[1] & cs_prev_q;

    assign w_byte_load = (state_q == ST_LOAD) && byte_done_q && (pix_cnt_q != C_PIX_TOTAL);
    assign w_pix_done  = w_byte_load && (byte_cnt_q == C_CH_LAST);
    assign w_last_wr   = wr_en_q && (addr_q == C_ADDR_LAST);
    // A frame counts as complete even if CS rises in the same clk as its last write.
    assign w_load_full = (pix_cnt_q == C_PIX_TOTAL) || (w_pix_done && (pix_cnt_q == C_PIX_LAST));

    generate
        if (CHANNELS == 1) begin : g_pix_single
            assign w_pix_next = rx_byte_q;
        end else begin : g_pix_multi
            logic [PIX_W-9:0] pix_q;
            always_ff @(posedge clk) begin
                if (rst) begin
                    pix_q <= '0;
                end else if (w_byte_load) begin
                    pix_q <= w_pix_next[PIX_W-9:0];
                end
            end
            assign w_pix_next = {pix_q, rx_byte_q};
        end
    endgenerate

    // CS sync resets low so a transaction already in flight at reset release is not re-armed.
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            cs_sync_q   <= '0;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[0], bus.SPI_CLK};
            mosi_sync_q <= {mosi_sync_q[0], bus.SPI_MOSI};
            cs_sync_q   <= {cs_sync_q[0], bus.SPI_CS};
            sclk_prev_q <= sclk_sync_q[1];
            cs_prev_q   <= cs_sync_q[1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            rx_byte_q   <= '0;
            byte_done_q <= 1'b0;
        end else begin
            byte_done_q <= 1'b0;
            if ((state_q == ST_IDLE) || cs_sync_q[1]) begin
                bit_cnt_q <= '0;
            end else if (w_sclk_rise) begin
                rx_sh_q   <= {rx_sh_q[5:0], mosi_sync_q[1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
                if (bit_cnt_q == 3'd7) begin
                    rx_byte_q   <= {rx_sh_q, mosi_sync_q[1]};
                    byte_done_q <= 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (w_cs_fall) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (byte_done_q) begin
                    if (rx_byte_q == C_CMD_LOAD)      state_d = ST_LOAD;
                    else if (rx_byte_q == C_CMD_READ) state_d = ST_READBACK;
                    else                              state_d = ST_DRAIN;
                end
            end
            ST_LOAD: begin
                if (w_last_wr) state_d = ST_DRAIN;
            end
            ST_READBACK, ST_DRAIN: begin
                state_d = state_q;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (w_cs_rise) state_d = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            byte_cnt_q     <= '0;
            pix_cnt_q      <= '0;
            addr_q         <= '0;
            wr_en_q        <= 1'b0;
            wdata_q        <= '0;
            rd_req_q       <= 1'b0;
            rd_cap_q       <= 1'b0;
            rd_buf_q       <= '0;
            tx_sh_q        <= '0;
            tx_bits_q      <= '0;
            tx_pix_q       <= '0;
            miso_q         <= 1'b0;
            dv_q           <= 1'b0;
            frame_loaded_q <= 1'b0;
            err_q          <= 1'b0;
            first_pend_q   <= 1'b0;
            first_byte_q   <= '0;
            last_byte_q    <= '0;
            curr_byte_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_en_q  <= 1'b0;
            rd_req_q <= 1'b0;
            rd_cap_q <= rd_req_q;
            if (rd_cap_q) rd_buf_q <= bus.mem_rdata;
            if (w_last_wr) frame_loaded_q <= 1'b1;

            if (byte_done_q) curr_byte_q <= rx_byte_q;
            if ((state_q == ST_IDLE) && w_cs_fall) begin
                first_pend_q <= 1'b1;
            end else if (byte_done_q && first_pend_q) begin
                first_byte_q <= rx_byte_q;
                first_pend_q <= 1'b0;
            end
            if (w_cs_rise && (state_q != ST_IDLE)) begin
                last_byte_q <= byte_done_q ? rx_byte_q : curr_byte_q;
            end

            if (state_q != ST_READBACK) begin
                miso_q <= 1'b0;
                dv_q   <= 1'b0;
            end

            case (state_q)
                ST_CMD: begin
                    if (byte_done_q) begin
                        if (rx_byte_q == C_CMD_LOAD) begin
                            pix_cnt_q      <= '0;
                            byte_cnt_q     <= '0;
                            frame_loaded_q <= 1'b0;
                        end else if (rx_byte_q == C_CMD_READ) begin
                            addr_q    <= '0;
                            rd_req_q  <= 1'b1;
                            tx_pix_q  <= '0;
                            tx_bits_q <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (w_byte_load) begin
                        if (w_pix_done) begin
                            byte_cnt_q <= '0;
                            wr_en_q    <= 1'b1;
                            wdata_q    <= w_pix_next;
                            addr_q     <= pix_cnt_q[ADDR_W-1:0];
                            pix_cnt_q  <= pix_cnt_q + CNT_W'(1);
                        end else begin
                            byte_cnt_q <= byte_cnt_q + 2'd1;
                        end
                    end
                    if (w_cs_rise && !w_load_full) err_q <= 1'b1;
                end
                ST_READBACK: begin
                    if (w_cs_rise) begin
                        miso_q <= 1'b0;
                        dv_q   <= 1'b0;
                    end else if (w_sclk_fall) begin
                        if (tx_bits_q != '0) begin
                            miso_q    <= tx_sh_q[PIX_W-1];
                            tx_sh_q   <= tx_sh_q << 1;
                            tx_bits_q <= tx_bits_q - BIT_W'(1);
                        end else if (tx_pix_q != C_PIX_TOTAL) begin
                            // Pixel boundary: present the prefetched word and fetch the next one.
                            miso_q    <= rd_buf_q[PIX_W-1];
                            tx_sh_q   <= rd_buf_q << 1;
                            tx_bits_q <= C_PIX_BITS - BIT_W'(1);
                            tx_pix_q  <= tx_pix_q + CNT_W'(1);
                            dv_q      <= 1'b1;
                            if (tx_pix_q != C_PIX_LAST) begin
                                addr_q   <= addr_q + ADDR_W'(1);
                                rd_req_q <= 1'b1;
                            end
                        end else begin
                            miso_q <= 1'b0;
                            dv_q   <= 1'b0;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (byte_done_q && frame_loaded_q) err_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.SPI_MISO     = miso_q;
    assign bus.data_valid   = dv_q;
    assign bus.mem_addr     = addr_q;
    assign bus.mem_wr_en    = wr_en_q;
    assign bus.mem_wdata    = wdata_q;
    assign bus.frame_loaded = frame_loaded_q;
    assign bus.err          = err_q;
    assign bus.first_byte   = first_byte_q;
    assign bus.last_byte    = last_byte_q;
    assign bus.curr_byte    = curr_byte_q;
endmodule
`default_nettype wire
